// File: rtl/car_pkg.sv
// Shared drive-path definitions: command encodings, FSM states, duty width
// and the command-to-target decode used by the PWM controller.
package car_pkg;

    localparam int unsigned DUTY_W = 8;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_LEFT  = 2'b10,
        CMD_RIGHT = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DUTY_W-1:0] l;
        logic [DUTY_W-1:0] r;
    } duty_pair_t;

    // Turning slows the inner wheel; the outer wheel keeps cruise duty.
    function automatic duty_pair_t decode_targets(
        input cmd_t              cmd,
        input logic [DUTY_W-1:0] cruise,
        input logic [DUTY_W-1:0] turn
    );
        duty_pair_t t;
        case (cmd)
            CMD_FWD: begin
                t.l = cruise;
                t.r = cruise;
            end
            CMD_LEFT: begin
                t.l = turn;
                t.r = cruise;
            end
            CMD_RIGHT: begin
                t.l = cruise;
                t.r = turn;
            end
            default: begin
                t.l = '0;
                t.r = '0;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One wheel: ramps the applied duty toward its target at period boundaries,
// clears at once on stop, and produces the registered PWM bit.
module pwm_ramp_channel
    import car_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DUTY_W-1:0] i_tgt,
    input  logic              i_pb,
    input  logic              i_stop,
    input  logic [DUTY_W-1:0] i_cnt_nxt,
    output logic [DUTY_W-1:0] o_cur,
    output logic              o_pwm,
    output logic              o_at_tgt
);

    localparam logic [DUTY_W:0] LP_STEP = (DUTY_W + 1)'(RAMP_STEP);

    logic [DUTY_W-1:0] r_cur;
    logic              r_pwm;
    logic [DUTY_W:0]   w_cur9;
    logic [DUTY_W:0]   w_tgt9;
    logic [DUTY_W:0]   w_delta;
    logic [DUTY_W:0]   w_step;
    logic [DUTY_W:0]   w_ramp9;
    logic [DUTY_W:0]   w_cur_nxt9;

    // Step is clamped to the remaining distance, so the result never overshoots or wraps.
    always_comb begin
        w_cur9  = {1'b0, r_cur};
        w_tgt9  = {1'b0, i_tgt};
        w_delta = '0;
        w_step  = '0;
        w_ramp9 = w_cur9;
        if (w_cur9 < w_tgt9) begin
            w_delta = w_tgt9 - w_cur9;
            w_step  = (w_delta < LP_STEP) ? w_delta : LP_STEP;
            w_ramp9 = w_cur9 + w_step;
        end else if (w_cur9 > w_tgt9) begin
            w_delta = w_cur9 - w_tgt9;
            w_step  = (w_delta < LP_STEP) ? w_delta : LP_STEP;
            w_ramp9 = w_cur9 - w_step;
        end

        if (i_stop) begin
            w_cur_nxt9 = '0;
        end else if (i_pb) begin
            w_cur_nxt9 = w_ramp9;
        end else begin
            w_cur_nxt9 = w_cur9;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cur <= w_cur_nxt9[DUTY_W-1:0];
            r_pwm <= ({1'b0, i_cnt_nxt} < w_cur_nxt9);
        end
    end

    // Looks ahead: true when the duty applied after this edge equals a non-zero target.
    assign o_at_tgt = (w_cur_nxt9 == w_tgt9) && (i_tgt != '0);
    assign o_cur    = r_cur;
    assign o_pwm    = r_pwm;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Two-wheel PWM controller: prescaled 8-bit PWM timebase, command decode,
// ramp/run FSM and two ramping PWM channels feeding the H-bridge enables.
module motor_pwm_ctrl
    import car_pkg::*;
#(
    parameter int unsigned PRESC_DIV   = 50,
    parameter int unsigned CRUISE_DUTY = 200,
    parameter int unsigned TURN_DUTY   = 60,
    parameter int unsigned RAMP_STEP   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [1:0]        CMD,
    output logic              PWM_L,
    output logic              PWM_R,
    output logic [DUTY_W-1:0] DUTY_L,
    output logic [DUTY_W-1:0] DUTY_R,
    output logic              AT_SPEED
);

    localparam int unsigned               LP_PRESC_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [LP_PRESC_W-1:0]     LP_PRESC_LAST = LP_PRESC_W'(PRESC_DIV - 1);
    localparam logic [DUTY_W-1:0]         LP_CRUISE     = DUTY_W'(CRUISE_DUTY);
    localparam logic [DUTY_W-1:0]         LP_TURN       = DUTY_W'(TURN_DUTY);

    logic [LP_PRESC_W-1:0] r_presc;
    logic [DUTY_W-1:0]     r_cnt;
    state_t                r_state;
    logic                  r_at_speed;

    logic                  w_tick;
    logic                  w_pb;
    logic [DUTY_W-1:0]     w_cnt_nxt;
    logic                  w_stop;
    duty_pair_t            w_tgt;
    logic                  w_at_l;
    logic                  w_at_r;
    logic                  w_both_at;

    assign w_tick    = (r_presc == LP_PRESC_LAST);
    assign w_pb      = w_tick && (r_cnt == '1);
    assign w_cnt_nxt = w_tick ? r_cnt + 1'b1 : r_cnt;
    assign w_stop    = (cmd_t'(CMD) == CMD_STOP);
    assign w_tgt     = decode_targets(cmd_t'(CMD), LP_CRUISE, LP_TURN);
    assign w_both_at = w_at_l && w_at_r;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stop bypasses the ramp and the period boundary; it takes effect on the next edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_at_speed <= 1'b0;
        end else if (w_stop) begin
            r_state    <= ST_IDLE;
            r_at_speed <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_RAMP;
                    r_at_speed <= 1'b0;
                end
                ST_RAMP: begin
                    if (w_both_at) begin
                        r_state    <= ST_RUN;
                        r_at_speed <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_both_at) begin
                        r_state    <= ST_RAMP;
                        r_at_speed <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_at_speed <= 1'b0;
                end
            endcase
        end
    end

    pwm_ramp_channel #(
        .RAMP_STEP(RAMP_STEP)
    ) u_chan_l (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_tgt    (w_tgt.l),
        .i_pb     (w_pb),
        .i_stop   (w_stop),
        .i_cnt_nxt(w_cnt_nxt),
        .o_cur    (DUTY_L),
        .o_pwm    (PWM_L),
        .o_at_tgt (w_at_l)
    );

    pwm_ramp_channel #(
        .RAMP_STEP(RAMP_STEP)
    ) u_chan_r (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_tgt    (w_tgt.r),
        .i_pb     (w_pb),
        .i_stop   (w_stop),
        .i_cnt_nxt(w_cnt_nxt),
        .o_cur    (DUTY_R),
        .o_pwm    (PWM_R),
        .o_at_tgt (w_at_r)
    );

    assign AT_SPEED = r_at_speed;

endmodule
